// File: rtl/stopwatch_counter.sv
// Stopwatch counting mm:ss.cc in BCD from a base_tick timebase with run/pause/clear control.
// Define STOPWATCH_LAP_EN to add the lap input and the lap_active display-freeze feature.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        base_tick,
    input  logic        start_stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
    output logic        lap_active,
`endif
    output logic [23:0] bcd_out,
    output logic        running,
    output logic        rollover
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  presc_q, presc_d;
    logic [23:0] cnt_q, cnt_d;
    logic        rollover_q, rollover_d;
    logic        cnt_tick;

    // One-centisecond BCD increment; bit 24 flags the 59:59.99 -> 00:00.00 wrap.
    function automatic logic [24:0] bcd_inc(input logic [23:0] v);
        logic [3:0] cs_o, cs_t, s_o, s_t, m_o, m_t;
        logic       carry;
        {m_t, m_o, s_t, s_o, cs_t, cs_o} = v;
        carry = 1'b1;
        if (cs_o >= 4'd9) cs_o = 4'd0;
        else begin cs_o = cs_o + 4'd1; carry = 1'b0; end
        if (carry) begin
            if (cs_t >= 4'd9) cs_t = 4'd0;
            else begin cs_t = cs_t + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (s_o >= 4'd9) s_o = 4'd0;
            else begin s_o = s_o + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (s_t >= 4'd5) s_t = 4'd0;
            else begin s_t = s_t + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (m_o >= 4'd9) m_o = 4'd0;
            else begin m_o = m_o + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (m_t >= 4'd5) m_t = 4'd0;
            else begin m_t = m_t + 4'd1; carry = 1'b0; end
        end
        return {carry, m_t, m_o, s_t, s_o, cs_t, cs_o};
    endfunction

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        rollover_d = 1'b0;
        // Ticks count against the registered state, so a tick alongside start_stop in RUN still counts.
        cnt_tick   = base_tick && (state_q == ST_RUN);
        if (clear) begin
            state_d = ST_IDLE;
            presc_d = 8'd0;
            cnt_d   = 24'd0;
        end else begin
            if (start_stop) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end
            if (cnt_tick) begin
                if (presc_q >= PRESC_MAX) begin
                    presc_d                = 8'd0;
                    {rollover_d, cnt_d}    = bcd_inc(cnt_q);
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= 8'd0;
            cnt_q      <= 24'd0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            rollover_q <= rollover_d;
        end
    end

    assign running  = (state_q == ST_RUN);
    assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic        frozen_q, frozen_d;
    logic [23:0] snap_q, snap_d;

    // Lap freezes the display on the current count while counting continues underneath.
    always_comb begin
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if (clear) begin
            frozen_d = 1'b0;
        end else if (lap) begin
            if (state_q == ST_RUN) begin
                frozen_d = !frozen_q;
                if (!frozen_q) snap_d = cnt_q;
            end else if (state_q == ST_PAUSE) begin
                frozen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) frozen_q <= 1'b0;
        else       frozen_q <= frozen_d;
        snap_q <= snap_d;
    end

    assign lap_active = frozen_q;
    assign bcd_out    = frozen_q ? snap_q : cnt_q;
`else
    assign bcd_out = cnt_q;
`endif

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, giving the number of base_tick pulses per centisecond increment; legal range 1..255.
REQ-002 SHALL have port sys_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port base_tick, input, 1 bit: one-cycle timebase pulse (100 Hz nominal).
REQ-005 SHALL have port start_stop, input, 1 bit: one-cycle command pulse.
REQ-006 SHALL have port clear, input, 1 bit: one-cycle command pulse.
REQ-007 SHALL have port lap, input, 1 bit: one-cycle command pulse; present only with STOPWATCH_LAP_EN.
REQ-008 SHALL have port bcd_out, output, 24 bits: BCD display value; [23:20] min tens, [19:16] min ones, [15:12] sec tens, [11:8] sec ones, [7:4] cs tens, [3:0] cs ones.
REQ-009 SHALL have port running, output, 1 bit: high while in state RUN.
REQ-010 SHALL have port rollover, output, 1 bit: one-cycle pulse on wrap from 59:59.99 to 00:00.00.
REQ-011 SHALL have port lap_active, output, 1 bit: high while the display is frozen; present only with STOPWATCH_LAP_EN.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and PAUSE.
REQ-013 SHALL apply these transitions: start_stop moves IDLE to RUN, RUN to PAUSE and PAUSE to RUN.
REQ-014 SHALL, on clear in any state, go to IDLE, zero the count and the prescaler, and deassert lap_active; clear outranks start_stop and base_tick in the same cycle.
REQ-015 SHALL count base_tick only when the registered state is RUN.
- A tick coinciding with start_stop in RUN is counted.
- A tick coinciding with start_stop in IDLE or PAUSE is not counted.
REQ-016 SHALL use an internal prescaler 0..TICK_DIV-1 that advances on each counted tick and wraps, incrementing the centisecond count on wrap.
- The prescaler holds in PAUSE.
- It is zeroed in IDLE.
REQ-017 SHALL update the count as BCD.
- cs 99 to 00 carries into sec.
- sec 59 to 00 carries into min.
- min 59 to 00 wraps the whole count to 00:00.00, pulses rollover for one cycle and stays in RUN.
REQ-018 SHALL never let any BCD digit exceed 9, nor a tens digit of sec or min exceed 5.
REQ-019 SHALL make bcd_out and rollover registered, with an increment visible on the cycle after the tick edge (latency 1 clock).
REQ-020 SHALL hold the count unchanged in PAUSE and at zero in IDLE.

Reset
REQ-021 SHALL, on reset high at a rising sys_clk edge:
- set the state to IDLE;
- set the count, prescaler and bcd_out to 0;
- set running, rollover and lap_active to 0.
REQ-022 SHALL give reset priority over every other input, including mid-count and mid-lap.

Configuration
REQ-023 SHALL compile in lap-hold logic when STOPWATCH_LAP_EN is defined.
- A lap pulse in RUN toggles a freeze: bcd_out holds a snapshot while the internal count continues.
- A lap pulse in IDLE or PAUSE is ignored, except that a lap pulse in PAUSE releases an active freeze.
- lap_active reflects the freeze.
REQ-024 SHALL, without STOPWATCH_LAP_EN, omit the lap and lap_active ports and drive bcd_out from the live count at all times.

Verification
REQ-025 SHALL pass this reset check: reset for 2 cycles mid-RUN at count 00:12.34 -> bcd_out=0, running=0, state IDLE.
REQ-026 SHALL pass this basic-count check: TICK_DIV=1, start_stop, then 150 base_ticks -> bcd_out=24'h000150; start_stop, then 10 ticks -> value unchanged, running=0.
REQ-027 SHALL pass this rollover check: count 59:59.99 in RUN, 1 tick -> bcd_out=0, rollover high exactly 1 cycle, running=1.
REQ-028 SHALL pass this prescaler check: TICK_DIV=4, RUN, 7 ticks -> bcd_out=24'h000001; pause then resume, 1 tick -> 24'h000002.
REQ-029 SHALL pass this priority check: clear and start_stop in the same cycle as a tick in RUN -> IDLE, bcd_out=0.
REQ-030 SHALL pass this lap check (STOPWATCH_LAP_EN): lap at 00:01.00, 50 more ticks -> bcd_out=24'h000100, lap_active=1; lap again -> bcd_out=24'h000150, lap_active=0.
